lcd_pixel_pipe: RTL

//  Pixel stage directly downstream of the LCD sync generator.

---
 rtl/lcd_pixel_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_pixel_pipe.sv
// Pixel stage behind the LCD sync generator: windows a 1-bpp frame buffer onto the panel and expands it to RGB565.
// Optional build macro LCD_PIX_OUTLINE_EN draws a 1-pixel fg-coloured ring around the image.
module lcd_pixel_pipe #(
    parameter int IMG_W   = 100,
    parameter int IMG_H   = 100,
    parameter int POS_X   = 350,
    parameter int POS_Y   = 190,
    parameter int AW      = 16,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rest_n,
    input  logic          de_in,
    input  logic [10:0]   xofs,
    input  logic [10:0]   yofs,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic          ram_q,
    input  logic [15:0]   fg_color,
    input  logic [15:0]   bg_color,
    input  logic          col_wr,
    output logic          col_ack,
    output logic          frame_start,
    output logic          lcd_de,
    output logic [4:0]    lcd_r,
    output logic [5:0]    lcd_g,
    output logic [4:0]    lcd_b
);

    localparam logic [11:0] X_LO = 12'(POS_X);
    localparam logic [11:0] X_HI = 12'(POS_X + IMG_W);
    localparam logic [11:0] Y_LO = 12'(POS_Y);
    localparam logic [11:0] Y_HI = 12'(POS_Y + IMG_H);

    logic [11:0]   x_ext;
    logic [11:0]   y_ext;
    logic          in_x;
    logic          in_y;
    logic          in_win;
    logic [10:0]   x_rel;
    logic [10:0]   y_rel;
    logic [AW-1:0] addr_c;
    logic          frame_start_c;
    logic          apply_c;

    logic          de_in_q;
    logic          de_s0;
    logic [RAM_LAT-1:0] de_pipe;
    logic [RAM_LAT-1:0] win_pipe;

    logic [15:0]   fg_act;
    logic [15:0]   bg_act;
    logic [15:0]   fg_sh;
    logic [15:0]   bg_sh;
    logic          pending;
    logic [15:0]   pix_color;
    logic [15:0]   rgb;

    // Widened by one bit so POS+IMG limits near the 11-bit ceiling cannot wrap.
    assign x_ext  = {1'b0, xofs};
    assign y_ext  = {1'b0, yofs};
    assign in_x   = (x_ext >= X_LO) && (x_ext < X_HI);
    assign in_y   = (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign in_win = de_in && in_x && in_y;

    assign x_rel  = xofs - 11'(POS_X);
    assign y_rel  = yofs - 11'(POS_Y);
    assign addr_c = AW'(x_rel) + AW'(y_rel) * AW'(IMG_W);

    assign frame_start_c = de_in && !de_in_q && (yofs == 11'd0);
    assign apply_c       = frame_start_c && pending;

`ifdef LCD_PIX_OUTLINE_EN
    logic               ring_x;
    logic               ring_y;
    logic               in_ring;
    logic               ring_s0;
    logic [RAM_LAT-1:0] ring_pipe;

    assign ring_x  = ((x_ext + 12'd1) >= X_LO) && (x_ext <= X_HI);
    assign ring_y  = ((y_ext + 12'd1) >= Y_LO) && (y_ext <= Y_HI);
    assign in_ring = de_in && ring_x && ring_y && !(in_x && in_y);

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            ring_s0   <= 1'b0;
            ring_pipe <= '0;
        end else begin
            ring_s0      <= in_ring;
            ring_pipe[0] <= ring_s0;
            for (int i = 1; i < RAM_LAT; i++) begin
                ring_pipe[i] <= ring_pipe[i-1];
            end
        end
    end
`endif

    // S0: issue the frame-buffer read and start the DE delay line.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            ram_rd   <= 1'b0;
            ram_addr <= '0;
            de_s0    <= 1'b0;
            de_in_q  <= 1'b0;
        end else begin
            ram_rd   <= in_win;
            ram_addr <= in_win ? addr_c : '0;
            de_s0    <= de_in;
            de_in_q  <= de_in;
        end
    end

    // NOTE: the delay line is reset too, so a reset mid-frame leaves no stale DE in flight.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            de_pipe  <= '0;
            win_pipe <= '0;
        end else begin
            de_pipe[0]  <= de_s0;
            win_pipe[0] <= ram_rd;
            for (int i = 1; i < RAM_LAT; i++) begin
                de_pipe[i]  <= de_pipe[i-1];
                win_pipe[i] <= win_pipe[i-1];
            end
        end
    end

    // Shadow/active colour pair; active only moves at a frame start.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            fg_act      <= 16'hFFFF;
            bg_act      <= 16'h0000;
            fg_sh       <= 16'hFFFF;
            bg_sh       <= 16'h0000;
            pending     <= 1'b0;
            col_ack     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_start_c;
            col_ack     <= apply_c;
            if (apply_c) begin
                fg_act <= fg_sh;
                bg_act <= bg_sh;
            end
            if (col_wr) begin
                fg_sh   <= fg_color;
                bg_sh   <= bg_color;
                pending <= 1'b1;
            end else if (apply_c) begin
                pending <= 1'b0;
            end
        end
    end

    // NOTE: a default before any branch keeps this block purely combinational (no latch).
    always_comb begin
        pix_color = 16'h0000;
        if (win_pipe[RAM_LAT-1]) begin
            pix_color = ram_q ? fg_act : bg_act;
        end
`ifdef LCD_PIX_OUTLINE_EN
        else if (ring_pipe[RAM_LAT-1]) begin
            pix_color = fg_act;
        end
`endif
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            lcd_de <= 1'b0;
            rgb    <= 16'h0000;
        end else begin
            lcd_de <= de_pipe[RAM_LAT-1];
            rgb    <= de_pipe[RAM_LAT-1] ? pix_color : 16'h0000;
        end
    end

    assign lcd_r = rgb[15:11];
    assign lcd_g = rgb[10:5];
    assign lcd_b = rgb[4:0];

endmodule
